// File: rtl/mem_access_ctrl.sv
// Memory access controller: latches MAR/MDR from the CPU bus and sequences each
// RAM access through IDLE -> [WAIT] -> ACCESS -> DONE with a req/ack handshake.
module mem_access_ctrl #(
    parameter int DEPTH       = 9,
    parameter int WIDTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack,
    output logic             busy,
    output logic             err,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_wr_en,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t           state_r;
    state_t           state_s;
    logic [DEPTH-1:0] mar_r;
    logic [WIDTH-1:0] mdr_r;
    logic [3:0]       cnt_r;
    logic             we_r;
    logic             err_r;
    logic             out_of_range_s;

    // Any address bit above the RAM range makes the request invalid.
    function automatic logic addr_out_of_range(input logic [31:0] a);
        return (a >> DEPTH) != 32'd0;
    endfunction

    // Decode the out-of-range condition of the presented bus address.
    always_comb begin
        out_of_range_s = addr_out_of_range(addr);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (out_of_range_s) begin
                        state_s = ST_DONE;
                    end else if (WAIT_STATES == 0) begin
                        state_s = ST_ACCESS;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_s = ST_DONE;
            ST_DONE:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // MAR/MDR, latched direction, error flag and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_r <= '0;
            mdr_r <= '0;
            cnt_r <= 4'd0;
            we_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        mar_r <= addr[DEPTH-1:0];
                        we_r  <= we;
                        err_r <= out_of_range_s;
                        cnt_r <= CNT_INIT;
                        // An invalid write must not disturb what rdata shows.
                        if (we && !out_of_range_s) begin
                            mdr_r <= wdata;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!we_r) begin
                        mdr_r <= ram_rdata;
                    end
                end
                ST_DONE: begin
                    err_r <= err_r;
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded straight from registers so they never glitch.
    always_comb begin
        ack       = (state_r == ST_DONE);
        busy      = (state_r != ST_IDLE);
        err       = (state_r == ST_DONE) && err_r;
        ram_wr_en = (state_r == ST_ACCESS) && we_r;
        rdata     = mdr_r;
        ram_wdata = mdr_r;
        ram_addr  = mar_r;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_STATES=0 and 1), each with a
// bench RAM, checked every cycle against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int WS0 = 0;
    localparam int WS1 = 1;

    logic        clk;
    logic        rst_n;
    logic        preload;
    logic        chk_en;
    logic [1:0]  req, we, ack, busy, err, wr_en;
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic [8:0]  ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [31:0] ram_rdata [2];
    logic [31:0] ram       [2][512];

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]),
        .err(err[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_wr_en(wr_en[0]), .ram_rdata(ram_rdata[0])
    );

    mem_access_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]),
        .err(err[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_wr_en(wr_en[1]), .ram_rdata(ram_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata[0] = ram[0][ram_addr[0]];
    assign ram_rdata[1] = ram[1][ram_addr[1]];

    // Bench RAM: preload pattern is A5000000 | address, top word of RAM 0 special.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int a = 0; a < 512; a++) ram[i][a] <= 32'hA500_0000 | 32'(a);
                if (i == 0) ram[i][511] <= 32'h1234_5678;
            end else if (wr_en[i]) begin
                ram[i][ram_addr[i]] <= ram_wdata[i];
            end
        end
    end

    // Model: rem = busy cycles left; accepted request occupies WS+2 cycles, or 1 if invalid.
    int          m_rem [2];
    logic        m_we  [2];
    logic        m_oor [2];
    logic [8:0]  m_mar [2];
    logic [31:0] m_mdr [2];
    logic [31:0] m_mem [2][512];

    function automatic int ws_of(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_rem[i] <= 0;
                m_we[i]  <= 1'b0;
                m_oor[i] <= 1'b0;
                m_mar[i] <= 9'd0;
                m_mdr[i] <= 32'd0;
                if (preload) begin
                    for (int a = 0; a < 512; a++) m_mem[i][a] <= 32'hA500_0000 | 32'(a);
                    if (i == 0) m_mem[i][511] <= 32'h1234_5678;
                end
            end else if (m_rem[i] != 0) begin
                m_rem[i] <= m_rem[i] - 1;
                if (m_rem[i] == 2) begin
                    if (m_we[i]) m_mem[i][m_mar[i]] <= m_mdr[i];
                    else         m_mdr[i] <= m_mem[i][m_mar[i]];
                end
            end else if (req[i]) begin
                m_we[i]  <= we[i];
                m_oor[i] <= (addr[i][31:9] != 23'd0);
                m_mar[i] <= addr[i][8:0];
                if (we[i] && addr[i][31:9] == 23'd0) m_mdr[i] <= wdata[i];
                m_rem[i] <= (addr[i][31:9] != 23'd0) ? 1 : ws_of(i) + 2;
            end
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %h, expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("busy",      i, 32'(busy[i]),  32'(m_rem[i] != 0));
                check("ack",       i, 32'(ack[i]),   32'(m_rem[i] == 1));
                check("err",       i, 32'(err[i]),   32'(m_rem[i] == 1 && m_oor[i]));
                check("ram_wr_en", i, 32'(wr_en[i]), 32'(m_rem[i] == 2 && m_we[i] && !m_oor[i]));
                check("rdata",     i, rdata[i],      m_mdr[i]);
                check("ram_wdata", i, ram_wdata[i],  m_mdr[i]);
                check("ram_addr",  i, 32'(ram_addr[i]), 32'(m_mar[i]));
            end
        end
    end

    // One transaction; returns cycle index of ack (cycle after E0 is 0) or -1.
    task automatic do_txn(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int ack_k, output int wr_cnt,
                          output logic err_v, output logic [31:0] rd_v);
        @(negedge clk); #1;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        req[i] = 1'b0; we[i] = ~w; addr[i] = a ^ 32'h0000_0155; wdata[i] = ~d;
        ack_k = -1; wr_cnt = 0; err_v = 1'b0; rd_v = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wr_en[i]) wr_cnt++;
            if (ack[i]) begin
                ack_k = k; err_v = err[i]; rd_v = rdata[i];
                break;
            end
        end
    endtask

    int          k_v, wr_v, acks;
    logic        e_v, found;
    logic [31:0] r_v;
    int          mem_bad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; preload = 1'b0; chk_en = 1'b0; req = 2'b00; we = 2'b00;
        for (int i = 0; i < 2; i++) begin addr[i] = 32'd0; wdata[i] = 32'd0; end

        // Reset takes effect between clock edges.
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst ack",   i, 32'(ack[i]),   32'd0);
            check("rst busy",  i, 32'(busy[i]),  32'd0);
            check("rst err",   i, 32'(err[i]),   32'd0);
            check("rst wr_en", i, 32'(wr_en[i]), 32'd0);
            check("rst rdata", i, rdata[i],      32'd0);
        end
        preload = 1'b1;
        @(posedge clk); @(posedge clk); #1 preload = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        check("busy after release", 1, 32'(busy[1]), 32'd0);

        // Write then read, one wait state.
        do_txn(1, 1'b1, 32'h005, 32'hDEAD_BEEF, k_v, wr_v, e_v, r_v);
        check("wr ack cycle", 1, 32'(k_v), 32'd2);
        check("wr wr_en cycles", 1, 32'(wr_v), 32'd1);
        check("wr err", 1, 32'(e_v), 32'd0);
        do_txn(1, 1'b0, 32'h005, 32'h0, k_v, wr_v, e_v, r_v);
        check("rd ack cycle", 1, 32'(k_v), 32'd2);
        check("rd data", 1, r_v, 32'hDEAD_BEEF);
        check("rd wr_en cycles", 1, 32'(wr_v), 32'd0);

        // Zero wait states, top address.
        do_txn(0, 1'b0, 32'h1FF, 32'h0, k_v, wr_v, e_v, r_v);
        check("ws0 rd ack cycle", 0, 32'(k_v), 32'd1);
        check("ws0 rd data", 0, r_v, 32'h1234_5678);
        do_txn(0, 1'b1, 32'h1FF, 32'hCAFE_F00D, k_v, wr_v, e_v, r_v);
        check("ws0 wr ack cycle", 0, 32'(k_v), 32'd1);
        check("ws0 wr wr_en cycles", 0, 32'(wr_v), 32'd1);
        do_txn(0, 1'b0, 32'h1FF, 32'h0, k_v, wr_v, e_v, r_v);
        check("ws0 readback", 0, r_v, 32'hCAFE_F00D);

        // Out-of-range write and read.
        do_txn(1, 1'b1, 32'h200, 32'h1111_1111, k_v, wr_v, e_v, r_v);
        check("oor wr ack cycle", 1, 32'(k_v), 32'd0);
        check("oor wr err", 1, 32'(e_v), 32'd1);
        check("oor wr wr_en cycles", 1, 32'(wr_v), 32'd0);
        check("oor wr rdata", 1, r_v, 32'hDEAD_BEEF);
        check("oor wr mem[0]", 1, ram[1][0], 32'hA500_0000);
        do_txn(1, 1'b0, 32'h8000_0005, 32'h0, k_v, wr_v, e_v, r_v);
        check("oor rd err", 1, 32'(e_v), 32'd1);
        check("oor rd rdata", 1, r_v, 32'hDEAD_BEEF);

        // Requests while busy are ignored; req dropped during DONE.
        @(negedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h020; wdata[1] = 32'h5555_AAAA;
        @(posedge clk); #1;
        we[1] = 1'b0; addr[1] = 32'h030;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack[1]) begin
                acks++;
                check("busy mar", 1, 32'(ram_addr[1]), 32'h020);
                #1 req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        check("busy ack count", 1, 32'(acks), 32'd1);
        check("busy rdata", 1, rdata[1], 32'h5555_AAAA);

        // Abort a write to 0x010 during ACCESS.
        @(negedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h010; wdata[1] = 32'hBAD0_BAD0;
        @(posedge clk); #1 req[1] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_en[1]) begin found = 1'b1; break; end
        end
        check("abort reached access", 1, 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort wr_en", 1, 32'(wr_en[1]), 32'd0);
        check("abort ack", 1, 32'(ack[1]), 32'd0);
        check("abort busy", 1, 32'(busy[1]), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        do_txn(1, 1'b0, 32'h010, 32'h0, k_v, wr_v, e_v, r_v);
        check("abort readback", 1, r_v, 32'hA500_0010);

        // Bench RAM contents against the model memory.
        @(negedge clk);
        mem_bad = 0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 512; a++)
                if (ram[i][a] !== m_mem[i][a]) mem_bad++;
        check("memory image", 0, 32'(mem_bad), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
